// File: rtl/prbs4_checker.sv
// Purpose : self-synchronising checker for the PRBS-4 word stream (x^4+x^3+1, shift-left).
// Latency : 1 cycle; lock, error strobe, error count and zero flag are registered.
// Backpress: none; the checker always accepts, and cycles with in_valid=0 freeze all state.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   in_valid    : in_data carries a sequence word this cycle
//   in_data     : received 4-bit LFSR word
//   clr_err     : synchronous clear of err_cnt and zero_seen
//   locked      : checker is in LOCKED state
//   err_pulse   : one-cycle strobe, last sampled word mismatched while LOCKED
//   err_cnt     : saturating count of LOCKED mismatches
//   zero_seen   : sticky flag, an all-zero (lockup) word was sampled
module prbs4_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             zero_seen
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    // A counter reaching its *_LAST value means the current word is the one
    // that completes the run, so the state change happens on this word.
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [3:0]         prev_q,      prev_d;
    logic               prev_vld_q,  prev_vld_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
    logic               zero_seen_q, zero_seen_d;

    logic [3:0]         expected;
    logic               is_zero;
    logic               hit;

    // Next word the generator would emit after prev_q.
    assign expected = {prev_q[2:0], prev_q[3] ^ prev_q[2]};
    assign is_zero  = (in_data == 4'b0000);
    // The lockup word can never be a legal successor, even if prev_q were zero.
    assign hit      = (in_data == expected) && !is_zero;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        zero_seen_d = zero_seen_q;

        // Clear first, so an error or zero word on the same cycle lands on top.
        if (clr_err) begin
            err_cnt_d   = '0;
            zero_seen_d = 1'b0;
        end

        if (in_valid) begin
            if (is_zero) begin
                zero_seen_d = 1'b1;
            end

            unique case (state_q)
                ST_SEARCH: begin
                    prev_d     = in_data;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q && hit) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end

                ST_LOCKED: begin
                    if (hit) begin
                        prev_d     = in_data;
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_d != '1) begin
                            err_cnt_d = err_cnt_d + ERR_W'(1);
                        end
                        if (miss_cnt_q == MISS_LAST) begin
                            // Too many misses in a row: give up the flywheel
                            // and resynchronise from the received word.
                            state_d     = ST_SEARCH;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            prev_d      = in_data;
                        end else begin
                            // Flywheel: keep the local sequence running so a
                            // single corrupted word does not shift the phase.
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                            prev_d     = expected;
                        end
                    end
                end

                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: directed word streams with hand-derived expectations.
// Instance a uses default parameters; instance b uses ERR_W=2 with a large unlock
// threshold to exercise counter saturation.
module tb_prbs4_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a (defaults)
    logic        a_rst_n, a_in_valid, a_clr_err;
    logic [3:0]  a_in_data;
    logic        a_locked, a_err_pulse, a_zero_seen;
    logic [15:0] a_err_cnt;

    // Instance b (ERR_W=2, UNLOCK_CNT=15)
    logic        b_rst_n, b_in_valid, b_clr_err;
    logic [3:0]  b_in_data;
    logic        b_locked, b_err_pulse, b_zero_seen;
    logic [1:0]  b_err_cnt;

    prbs4_checker u_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .clr_err   (a_clr_err),
        .locked    (a_locked),
        .err_pulse (a_err_pulse),
        .err_cnt   (a_err_cnt),
        .zero_seen (a_zero_seen)
    );

    prbs4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(2)) u_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .clr_err   (b_clr_err),
        .locked    (b_locked),
        .err_pulse (b_err_pulse),
        .err_cnt   (b_err_cnt),
        .zero_seen (b_zero_seen)
    );

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic        zero;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    // PRBS-4 sequence from seed 0001, worked out by hand.
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: each cycle, compare the outputs produced by the previous
    // cycle's inputs against the queued expectation.
    always @(posedge clk) begin : mon_a
        exp_t e;
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a.locked",    {15'd0, a_locked},    {15'd0, e.locked});
            check("a.err_pulse", {15'd0, a_err_pulse}, {15'd0, e.pulse});
            check("a.err_cnt",   a_err_cnt,            e.cnt);
            check("a.zero_seen", {15'd0, a_zero_seen}, {15'd0, e.zero});
        end
    end

    always @(posedge clk) begin : mon_b
        exp_t e;
        #1;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b.locked",    {15'd0, b_locked},    {15'd0, e.locked});
            check("b.err_pulse", {15'd0, b_err_pulse}, {15'd0, e.pulse});
            check("b.err_cnt",   {14'd0, b_err_cnt},   e.cnt);
            check("b.zero_seen", {15'd0, b_zero_seen}, {15'd0, e.zero});
        end
    end

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic send(input bit sel, input logic vld, input logic [3:0] dat, input logic clr,
                        input logic el, input logic ep, input logic [15:0] ec, input logic ez);
        exp_t e;
        e.locked = el;
        e.pulse  = ep;
        e.cnt    = ec;
        e.zero   = ez;
        @(posedge clk);
        #2;
        if (!sel) begin
            a_in_valid = vld;
            a_in_data  = dat;
            a_clr_err  = clr;
            q_a.push_back(e);
        end else begin
            b_in_valid = vld;
            b_in_data  = dat;
            b_clr_err  = clr;
            q_b.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 16'(q_a.size() + q_b.size()), 16'd0);
    endtask

    // Asynchronous reset of instance a mid-stream; outputs must clear at once.
    task automatic reset_a();
        drain();
        a_rst_n = 1'b0;
        #1;
        check("rst.locked",    {15'd0, a_locked},    16'd0);
        check("rst.err_pulse", {15'd0, a_err_pulse}, 16'd0);
        check("rst.err_cnt",   a_err_cnt,            16'd0);
        check("rst.zero_seen", {15'd0, a_zero_seen}, 16'd0);
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = 4'h0; a_clr_err = 1'b0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = 4'h0; b_clr_err = 1'b0;
        #12;
        check("init.locked",    {15'd0, a_locked},    16'd0);
        check("init.err_pulse", {15'd0, a_err_pulse}, 16'd0);
        check("init.err_cnt",   a_err_cnt,            16'd0);
        check("init.zero_seen", {15'd0, a_zero_seen}, 16'd0);
        check("init.b_err_cnt", {14'd0, b_err_cnt},   16'd0);
        #6;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // 1: clean stream of 40 words, lock on the 5th, wrap 1000->0001 twice.
        for (int i = 0; i < 40; i++)
            send(0, 1'b1, seq[i % 15], 1'b0, (i >= 4), 1'b0, 16'd0, 1'b0);
        send(0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);

        // 2: isolated error (1101 sent as 1100), flywheel keeps the phase.
        for (int i = 10; i < 21; i++)
            send(0, 1'b1, seq[i % 15], 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        send(0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
        for (int i = 7; i < 15; i++)
            send(0, 1'b1, seq[i], 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
        send(0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);

        // 3: clear, then three consecutive bad words drop lock; relock after 5.
        send(0, 1'b1, seq[0], 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int i = 1; i < 6; i++)
            send(0, 1'b1, seq[i], 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        send(0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
        send(0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
        send(0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1);
        for (int i = 9; i < 13; i++)
            send(0, 1'b1, seq[i], 1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
        send(0, 1'b1, seq[13], 1'b0, 1'b1, 1'b0, 16'd3, 1'b1);
        // clr_err on a good word, then clr_err together with a zero word.
        send(0, 1'b1, seq[14], 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        send(0, 1'b1, 4'h0,    1'b1, 1'b1, 1'b1, 16'd1, 1'b1);
        send(0, 1'b1, seq[1],  1'b0, 1'b1, 1'b0, 16'd1, 1'b1);
        send(0, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0, 16'd1, 1'b1);

        // 6: reset mid-stream, then clean stream with idle gaps carrying junk.
        reset_a();
        for (int k = 0; k < 20; k++) begin
            send(0, 1'b1, seq[(5 + k) % 15], 1'b0, (k >= 4), 1'b0, 16'd0, 1'b0);
            send(0, 1'b0, 4'h0,              1'b0, (k >= 4), 1'b0, 16'd0, 1'b0);
        end

        // 4: all-zero stream never locks, only raises zero_seen.
        reset_a();
        for (int k = 0; k < 10; k++)
            send(0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        send(0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

        // 5: instance b, 2-bit counter saturates at 3; clear with error gives 1.
        for (int i = 0; i < 5; i++)
            send(1, 1'b1, seq[i], 1'b0, (i >= 4), 1'b0, 16'd0, 1'b0);
        send(1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
        send(1, 1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
        send(1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
        send(1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
        send(1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
        send(1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
        send(1, 1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
        send(1, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
        send(1, 1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
        send(1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
        send(1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0);
        send(1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
        send(1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);

        drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
